msx_slot_master: RTL and testbench
==================================

// Module: msx_slot_master
// PURPOSE
//  MSX cartridge-slot bus initiator: turns a valid/ready request (addr, we, wdata) into a
//  Z80-timed memory read/write cycle on slot_a/slot_d/strobes, returns read data.
//  Sits in the host-side FPGA / system harness driving scc_for_cartridge and peer cartridges.
// PARAMETERS
//  CLK_DIV     6  clk cycles per bus T-state (21.47727MHz/6 = 3.58MHz); even, >=4
//  EXTRA_WAIT  0  fixed wait T-states inserted after T3, 0..7
// PORTS
//  clk          in   1   system clock, 21.47727MHz
//  nreset       in   1   asynchronous reset, active-low (negative logic)
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept request
//  req_we       in   1   1=memory write, 0=memory read
//  req_addr     in   16  bus address
//  req_wdata    in   8   write data
//  resp_valid   out  1   1-clk pulse: cycle finished; rdata valid for reads
//  resp_rdata   out  8   data sampled from slot_d_in (reads); held until next read
//  slot_clk     out  1   bus clock, high for phase < CLK_DIV/2
//  slot_a       out  16  address
//  slot_d_out   out  8   write data; slot_d_oe  out 1  data bus drive enable
//  slot_d_in    in   8   data bus input (external tristate merge)
//  slot_nsltsl / slot_nmerq / slot_nrd / slot_nwr  out  1 each  strobes, negative logic
//  slot_nwait   in   1   wait request, negative logic (used only with SLOT_WAIT_EN)
// BEHAVIOUR
//  - Reset (async): state IDLE, phase=0, strobes=1, slot_a=0, slot_d_out=0, slot_d_oe=0,
//    resp_valid=0, resp_rdata=0, req_ready=0; req_ready=1 from first clk after release.
//  - phase: free-running 0..CLK_DIV-1 counter; tick = (phase==CLK_DIV-1). Never stalls.
//  - Accept on clk where req_valid&&req_ready: latch we/addr/wdata, req_ready<=0, go ARM.
//  - States, advance only on tick: IDLE->ARM->T1->T2->T3->[TW x EXTRA_WAIT]->T4->IDLE.
//  - T1 entry: slot_a<=addr, nmerq=0, nsltsl=0; read: nrd=0; write: slot_d_oe=1, d_out=wdata.
//  - T2 entry (write): nwr=0. Read strobes unchanged.
//  - End of last T3/TW (tick): read: resp_rdata<=slot_d_in; nrd,nwr,nmerq,nsltsl<=1.
//  - T4: slot_a, slot_d_out held; slot_d_oe held (write) to give data hold time.
//  - End of T4 (tick): slot_d_oe<=0, resp_valid=1 for that one clk, req_ready<=1, IDLE.
//  - Latency accept->resp_valid: wait-to-tick (1..CLK_DIV) + (4+EXTRA_WAIT)*CLK_DIV clks.
//  - One outstanding cycle; req_valid while req_ready=0 ignored (requester holds it).
//  - Completion and new req_valid same clk: new request accepted next clk, never dropped.
//  - Reset asserted mid-cycle: all strobes/oe return inactive immediately; no resp_valid.
//  - nrd and nwr never simultaneously low; slot_d_oe never 1 during a read.
// CONFIGURATION
//  SLOT_WAIT_EN defined: slot_nwait sampled at each tick ending T3/TW; while 0, stay in
//   that state (whole T-states), strobes held; data sampled on first tick with nwait=1.
//  SLOT_WAIT_EN undefined: slot_nwait ignored, unconnected-safe; timing purely parametric.
// TESTING
//  1 write 0x9000<=0x3F: nmerq/nsltsl low 3 T-states, nwr low 2, d_oe 4 T-states, 0x3F.
//  2 read 0x9800, bench drives slot_d_in=0x5A while nrd=0 -> resp_rdata=0x5A, pulse 1 clk.
//  3 EXTRA_WAIT=1 read: resp_valid exactly CLK_DIV=6 clks later than EXTRA_WAIT=0 case.
//  4 SLOT_WAIT_EN, slot_nwait=0 for 2 ticks in T3 -> strobes extended 12 clks, data OK.
//  5 nreset low during T2 of a write -> nwr/nmerq/nsltsl=1, d_oe=0 async; no resp_valid.
//  6 back-to-back 64 writes 0x9800..0x983F held req_valid -> 64 resp pulses, none lost.

Source files
------------

// File: rtl/msx_slot_master_if.sv
// msx_slot_master_if: host request/response handshake and MSX cartridge-slot bus signals
interface msx_slot_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        slot_clk;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe;
    logic [7:0]  slot_d_in;
    logic        slot_nsltsl;
    logic        slot_nmerq;
    logic        slot_nrd;
    logic        slot_nwr;
    logic        slot_nwait;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, slot_d_in, slot_nwait,
        output req_ready, resp_valid, resp_rdata, slot_clk, slot_a, slot_d_out, slot_d_oe,
               slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, slot_d_in, slot_nwait,
        input  req_ready, resp_valid, resp_rdata, slot_clk, slot_a, slot_d_out, slot_d_oe,
               slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
    );
endinterface

// File: rtl/msx_slot_master.sv
// msx_slot_master: valid/ready request to Z80-timed MSX slot memory cycle; SLOT_WAIT_EN enables slot_nwait stretching
module msx_slot_master #(
    parameter int CLK_DIV    = 6,
    parameter int EXTRA_WAIT = 0
) (
    input logic              clk,
    input logic              nreset,
    msx_slot_master_if.master bus
);
    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, ARM, T1, T2, T3, TW, T4} state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_nxt;
    logic            tick;
    logic            go;
    logic            last_wait;
    logic [2:0]      wcnt;
    logic            we;
    logic [15:0]     addr;
    logic [7:0]      wdata;

    assign tick      = phase == PW'(CLK_DIV - 1);
    assign phase_nxt = tick ? '0 : phase + 1'b1;
    assign last_wait = (state == T3) ? (EXTRA_WAIT == 0) : (wcnt == 3'(EXTRA_WAIT - 1));

`ifdef SLOT_WAIT_EN
    assign go = bus.slot_nwait;
`else
    logic unused_nwait;
    assign unused_nwait = bus.slot_nwait;
    assign go = 1'b1;
`endif

    // free-running T-state phase counter and the bus clock derived from it
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase        <= '0;
            bus.slot_clk <= 1'b1;
        end else begin
            phase        <= phase_nxt;
            bus.slot_clk <= phase_nxt < PW'(CLK_DIV / 2);
        end
    end

    // bus cycle sequencer; every state change lines up with a T-state boundary
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state           <= IDLE;
            wcnt            <= '0;
            we              <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            bus.req_ready   <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.slot_a      <= '0;
            bus.slot_d_out  <= '0;
            bus.slot_d_oe   <= 1'b0;
            bus.slot_nsltsl <= 1'b1;
            bus.slot_nmerq  <= 1'b1;
            bus.slot_nrd    <= 1'b1;
            bus.slot_nwr    <= 1'b1;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        we            <= bus.req_we;
                        addr          <= bus.req_addr;
                        wdata         <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        state         <= ARM;
                    end
                end
                ARM: if (tick) begin
                    state           <= T1;
                    bus.slot_a      <= addr;
                    bus.slot_nmerq  <= 1'b0;
                    bus.slot_nsltsl <= 1'b0;
                    bus.slot_nrd    <= we;
                    bus.slot_d_oe   <= we;
                    if (we) bus.slot_d_out <= wdata;
                end
                T1: if (tick) begin
                    state        <= T2;
                    bus.slot_nwr <= !we;
                end
                T2: if (tick) begin
                    state <= T3;
                    wcnt  <= '0;
                end
                T3, TW: if (tick && go) begin
                    if (last_wait) begin
                        state           <= T4;
                        if (!we) bus.resp_rdata <= bus.slot_d_in;
                        bus.slot_nrd    <= 1'b1;
                        bus.slot_nwr    <= 1'b1;
                        bus.slot_nmerq  <= 1'b1;
                        bus.slot_nsltsl <= 1'b1;
                    end else begin
                        state <= TW;
                        if (state == TW) wcnt <= wcnt + 1'b1;
                    end
                end
                T4: if (tick) begin
                    state          <= IDLE;
                    bus.slot_d_oe  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msx_slot_master.sv
// tb_msx_slot_master: directed bench for msx_slot_master (EXTRA_WAIT 0 and 1 instances; SLOT_WAIT_EN aware)
module tb_msx_slot_master;
    logic clk = 1'b0;
    logic nreset = 1'b1;
    logic [7:0] rd_val = 8'h00;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t_resp1 = 0;
    int t_resp2 = 0;
    int resp_cnt = 0;
    int n_merq, n_sltsl, n_rd, n_wr, n_oe, bad, t1, lat, stall;
    logic clk_at_t1;

    msx_slot_master_if bus ();
    msx_slot_master_if bus2 ();

    msx_slot_master #(.CLK_DIV(6), .EXTRA_WAIT(0)) dut (.clk(clk), .nreset(nreset), .bus(bus.master));
    msx_slot_master #(.CLK_DIV(6), .EXTRA_WAIT(1)) dut2 (.clk(clk), .nreset(nreset), .bus(bus2.master));

    assign bus.slot_d_in    = bus.slot_nrd ? 8'hFF : rd_val;
    assign bus2.slot_d_in   = bus2.slot_nrd ? 8'hFF : rd_val;
    assign bus2.req_valid   = bus.req_valid;
    assign bus2.req_we      = bus.req_we;
    assign bus2.req_addr    = bus.req_addr;
    assign bus2.req_wdata   = bus.req_wdata;
    assign bus2.slot_nwait  = 1'b1;

    always #5 clk = ~clk;

    // time-stamp response pulses of both instances
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.resp_valid) begin
            t_resp1 = cyc;
            resp_cnt = resp_cnt + 1;
        end
        if (bus2.resp_valid) t_resp2 = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // issue one request from a negedge, observe the cycle until resp_valid (returns at that negedge)
    task automatic run(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic hold);
        int k;
        logic timeout;
        bus.req_we = we;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        stall = 0;
        while (!bus.req_ready && stall < 100) begin
            @(negedge clk);
            stall++;
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        n_merq = 0; n_sltsl = 0; n_rd = 0; n_wr = 0; n_oe = 0; bad = 0; t1 = -1;
        clk_at_t1 = 1'b0;
        timeout = 1'b1;
        k = 0;
        while (k < 200) begin
            if (bus.resp_valid) begin
                timeout = 1'b0;
                break;
            end
            if (!bus.slot_nmerq) begin
                n_merq++;
                if (t1 < 0) begin
                    t1 = k;
                    clk_at_t1 = bus.slot_clk;
                end
                if (bus.slot_a != a) bad++;
            end
            if (!bus.slot_nsltsl) n_sltsl++;
            if (!bus.slot_nrd) n_rd++;
            if (!bus.slot_nwr) n_wr++;
            if (bus.slot_d_oe) begin
                n_oe++;
                if (bus.slot_d_out != wd) bad++;
            end
            if ((!bus.slot_nrd && !bus.slot_nwr) || (bus.slot_d_oe && !we)) bad++;
            @(negedge clk);
            k++;
        end
        lat = k;
        chk("resp_timeout", {31'b0, timeout}, 32'd0);
    endtask

    initial begin
        int rc;
        int errs;
        int stalls;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.slot_nwait = 1'b1;
        #1 nreset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_rdata", {24'b0, bus.resp_rdata}, 32'd0);
        chk("rst_addr", {16'b0, bus.slot_a}, 32'd0);
        chk("rst_dout_oe", {23'b0, bus.slot_d_out, bus.slot_d_oe}, 32'd0);
        chk("rst_strobes", {28'b0, bus.slot_nsltsl, bus.slot_nmerq, bus.slot_nrd, bus.slot_nwr}, 32'hF);
        nreset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

        // read 0x9800 on both instances: data capture, pulse width, EXTRA_WAIT latency delta
        rd_val = 8'h5A;
        run(1'b0, 16'h9800, 8'h00, 1'b0);
        chk("rd_rdata", {24'b0, bus.resp_rdata}, 32'h5A);
        chk("rd_nrd_len", n_rd, 18);
        chk("rd_nmerq_len", n_merq, 18);
        chk("rd_nwr_len", n_wr, 0);
        chk("rd_oe_len", n_oe, 0);
        chk("rd_bad", bad, 0);
        chk("rd_t1_to_resp", lat - t1, 24);
        chk("rd_latency_range", {31'b0, lat >= 25 && lat <= 30}, 32'd1);
        chk("rd_slot_clk_t1", {31'b0, clk_at_t1}, 32'd1);
        @(negedge clk);
        chk("resp_pulse_1clk", {31'b0, bus.resp_valid}, 32'd0);
        rc = 0;
        while (!bus2.resp_valid && rc < 20) begin
            @(negedge clk);
            rc++;
        end
        @(negedge clk);
        chk("ew1_delta", t_resp2 - t_resp1, 6);
        chk("ew1_rdata", {24'b0, bus2.resp_rdata}, 32'h5A);

        // write 0x9000 <= 0x3F
        rd_val = 8'h11;
        run(1'b1, 16'h9000, 8'h3F, 1'b0);
        chk("wr_nmerq_len", n_merq, 18);
        chk("wr_nsltsl_len", n_sltsl, 18);
        chk("wr_nwr_len", n_wr, 12);
        chk("wr_nrd_len", n_rd, 0);
        chk("wr_oe_len", n_oe, 24);
        chk("wr_bad", bad, 0);
        chk("wr_t1_to_resp", lat - t1, 24);
        chk("wr_rdata_held", {24'b0, bus.resp_rdata}, 32'h5A);

        // read with slot_nwait low over two ticks ending T3
        rd_val = 8'hC3;
        fork
            run(1'b0, 16'h9801, 8'h00, 1'b0);
            begin
                int j = 0;
                while (bus.slot_nmerq && j < 100) begin
                    @(negedge clk);
                    j++;
                end
                repeat (14) @(negedge clk);
                bus.slot_nwait = 1'b0;
                repeat (12) @(negedge clk);
                bus.slot_nwait = 1'b1;
            end
        join
        chk("wt_rdata", {24'b0, bus.resp_rdata}, 32'hC3);
        chk("wt_bad", bad, 0);
`ifdef SLOT_WAIT_EN
        chk("wt_nrd_len", n_rd, 30);
        chk("wt_t1_to_resp", lat - t1, 36);
`else
        chk("wt_nrd_len", n_rd, 18);
        chk("wt_t1_to_resp", lat - t1, 24);
`endif

        // reset during T2 of a write
        rc = resp_cnt;
        bus.req_we = 1'b1;
        bus.req_addr = 16'h9123;
        bus.req_wdata = 8'h77;
        bus.req_valid = 1'b1;
        stall = 0;
        while (!bus.req_ready && stall < 100) begin
            @(negedge clk);
            stall++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        stall = 0;
        while (bus.slot_nwr && stall < 100) begin
            @(negedge clk);
            stall++;
        end
        chk("rs_nwr_seen", {31'b0, bus.slot_nwr}, 32'd0);
        repeat (2) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("rs_strobes", {28'b0, bus.slot_nsltsl, bus.slot_nmerq, bus.slot_nrd, bus.slot_nwr}, 32'hF);
        chk("rs_oe", {31'b0, bus.slot_d_oe}, 32'd0);
        chk("rs_ready", {31'b0, bus.req_ready}, 32'd0);
        repeat (8) @(negedge clk);
        nreset = 1'b1;
        repeat (40) @(negedge clk);
        chk("rs_no_resp", resp_cnt - rc, 0);
        chk("rs_ready_back", {31'b0, bus.req_ready}, 32'd1);

        // 64 back-to-back writes with req_valid held
        rc = resp_cnt;
        errs = 0;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            run(1'b1, 16'h9800 + 16'(i), 8'(i) ^ 8'hA5, 1'b1);
            if (n_wr != 12 || n_oe != 24) errs++;
            errs += bad;
            stalls += stall;
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_resp_count", resp_cnt - rc, 64);
        chk("b2b_errors", errs, 0);
        chk("b2b_stalls", stalls, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
